// File: rtl/sw_debounce_core_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_core_if
// Avalon-MM slave bus bundle for the slide-switch debounce core.
//
// Signals
//   avs_address    [1:0]   word address of register
//   avs_read               read strobe
//   avs_readdata   [31:0]  read data, valid the cycle after avs_read
//   avs_write              write strobe
//   avs_writedata  [31:0]  write data
//
// Modports
//   master  drives address/strobes/write data, samples read data
//   slave   the core side
// -----------------------------------------------------------------------------
interface sw_debounce_core_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        avs_write;
   logic [31:0] avs_writedata;

   modport master (
      output avs_address,
      output avs_read,
      output avs_write,
      output avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_read,
      input  avs_write,
      input  avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/sw_debounce_core.sv
// -----------------------------------------------------------------------------
// sw_debounce_core
// Avalon-MM slave that reads the board slide switches. Each raw switch input
// is passed through a 2-flop synchroniser and a per-bit debounce counter; the
// accepted (stable) value is readable, every stable change latches a sticky
// W1C edge bit, and unmasked edge bits drive a registered level interrupt.
//
// Parameters
//   N_SW             number of switch inputs (1..32)
//   DEBOUNCE_CYCLES  consecutive cycles an input must differ from the stable
//                    value before it is accepted (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk        system clock, single domain
//   reset_n    asynchronous active-low reset
//   avs        Avalon-MM slave bus (sw_debounce_core_if.slave)
//   sw_in      raw asynchronous switch inputs
//   irq        level interrupt, active high
//
// Register map (32-bit words, unused bits read 0)
//   0  DATA   RO   stable switch value
//   1  EDGE   W1C  sticky edge bits
//   2  MASK   RW   irq enable per bit
//   3  EVCNT  RO, write clears; accepted rising-edge count (optional)
//
// Optional feature macro: SW_DEBOUNCE_CORE_EVCNT_EN
//   defined   : 32-bit saturating count of accepted rising edges at address 3
//   undefined : no counter logic, address 3 reads 0 and writes are ignored
// -----------------------------------------------------------------------------
module sw_debounce_core #(
   parameter int N_SW            = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   sw_debounce_core_if.slave   avs,
   input  logic [N_SW-1:0]     sw_in,
   output logic                irq
);

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_EDGE  = 2'd1;
   localparam logic [1:0] ADDR_MASK  = 2'd2;
   localparam logic [1:0] ADDR_EVCNT = 2'd3;

   // terminal count: the DEBOUNCE_CYCLES-th consecutive differing cycle
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_SW-1:0]  sync_1;
   logic [N_SW-1:0]  sync_2;
   logic [N_SW-1:0]  stable;
   logic [N_SW-1:0]  stable_d;
   logic [N_SW-1:0]  edge_bits;
   logic [N_SW-1:0]  mask;
   logic [CNT_W-1:0] cnt [N_SW];

   logic [N_SW-1:0]  new_edge;
   logic [N_SW-1:0]  edge_clr;
   logic [31:0]      rd_mux;
   logic             wr_edge;
   logic             wr_mask;

   // upper write-data bits are don't-care for narrow switch counts
   logic unused_wdata;
   assign unused_wdata = ^avs.avs_writedata;

   // ---------------------------------------------------------------------
   // Synchroniser: two flops per bit, raw input is asynchronous
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= sw_in;
         sync_2 <= sync_1;
      end
   end

   // ---------------------------------------------------------------------
   // Debounce: counter runs only while the synchronised input disagrees
   // with the stable value; any return to agreement discards the count.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
         for (int i = 0; i < N_SW; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_SW; i++) begin
            if (sync_2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == TERM_CNT) begin
               stable[i] <= sync_2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Edge detect on the stable value (either direction), one cycle after
   // stable updates.
   // ---------------------------------------------------------------------
   assign new_edge = stable ^ stable_d;

   assign wr_edge  = avs.avs_write && (avs.avs_address == ADDR_EDGE);
   assign wr_mask  = avs.avs_write && (avs.avs_address == ADDR_MASK);
   assign edge_clr = wr_edge ? avs.avs_writedata[N_SW-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d  <= '0;
         edge_bits <= '0;
         mask      <= '0;
      end else begin
         stable_d  <= stable;
         // a new edge in the same cycle as its W1C keeps the bit set
         edge_bits <= (edge_bits & ~edge_clr) | new_edge;
         if (wr_mask) begin
            mask <= avs.avs_writedata[N_SW-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Optional accepted-rising-edge counter
   // ---------------------------------------------------------------------
`ifdef SW_DEBOUNCE_CORE_EVCNT_EN
   logic [N_SW-1:0] rise;
   logic [5:0]      rise_cnt;
   logic [32:0]     ev_sum;
   logic [31:0]     evcnt;
   logic            wr_evcnt;

   assign rise     = stable & ~stable_d;
   assign wr_evcnt = avs.avs_write && (avs.avs_address == ADDR_EVCNT);

   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < N_SW; i++) begin
         rise_cnt = rise_cnt + 6'(rise[i]);
      end
   end

   // one extra bit so overflow can be detected and clamped
   assign ev_sum = {1'b0, evcnt} + 33'(rise_cnt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evcnt <= '0;
      end else if (wr_evcnt) begin
         evcnt <= '0;
      end else if (ev_sum[32]) begin
         evcnt <= '1;
      end else begin
         evcnt <= ev_sum[31:0];
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Read path: mux of pre-write register values, registered, zero when
   // the previous cycle carried no read.
   // ---------------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         ADDR_DATA:  rd_mux[N_SW-1:0] = stable;
         ADDR_EDGE:  rd_mux[N_SW-1:0] = edge_bits;
         ADDR_MASK:  rd_mux[N_SW-1:0] = mask;
`ifdef SW_DEBOUNCE_CORE_EVCNT_EN
         ADDR_EVCNT: rd_mux           = evcnt;
`else
         ADDR_EVCNT: rd_mux           = '0;
`endif
         default:    rd_mux           = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs.avs_readdata <= '0;
      end else if (avs.avs_read) begin
         avs.avs_readdata <= rd_mux;
      end else begin
         avs.avs_readdata <= '0;
      end
   end

   // ---------------------------------------------------------------------
   // Interrupt: registered OR of unmasked sticky edges
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(edge_bits & mask);
      end
   end

endmodule

// File: tb/tb_sw_debounce_core.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce_core
// Directed and randomized bench for sw_debounce_core (N_SW=4,
// DEBOUNCE_CYCLES=8). The reference model decides acceptance with a sliding
// window: a stable bit flips once the last DEBOUNCE_CYCLES synchronised
// samples all disagree with it. irq and readdata are compared every cycle.
// -----------------------------------------------------------------------------
module tb_sw_debounce_core;

   localparam int N  = 4;
   localparam int D  = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] sw_in;
   logic         irq;

   sw_debounce_core_if bus ();

   sw_debounce_core #(
      .N_SW            (N),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .avs     (bus),
      .sw_in   (sw_in),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int chk_total = 0;
   int chk_pass  = 0;
   int chk_fail  = 0;

   // reference model state
   logic [N-1:0] m_q [$];
   logic [N-1:0] m_stable, m_stable_d, m_edge, m_mask;
   logic         m_irq;
   logic [31:0]  m_rd;
   logic [31:0]  m_evcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_total++;
      assert (obs === exp) chk_pass++;
      else begin
         chk_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int k = 0; k <= D; k++) m_q.push_back('0);
      m_stable   = '0;
      m_stable_d = '0;
      m_edge     = '0;
      m_mask     = '0;
      m_irq      = 1'b0;
      m_rd       = '0;
      m_evcnt    = '0;
   endtask

   function automatic logic [31:0] model_reg(input logic [1:0] a);
      case (a)
         2'd0: return {28'd0, m_stable};
         2'd1: return {28'd0, m_edge};
         2'd2: return {28'd0, m_mask};
`ifdef SW_DEBOUNCE_CORE_EVCNT_EN
         default: return m_evcnt;
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   // Advance the model across one rising clock edge using the inputs
   // currently applied.
   task automatic model_step();
      logic [N-1:0] clr, nxt_stable, rises;
      logic [32:0]  sum;
      bit           flip;
      int           pop;
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_rd  = bus.avs_read ? model_reg(bus.avs_address) : 32'd0;
      m_irq = |(m_edge & m_mask);
      clr   = (bus.avs_write && bus.avs_address == 2'd1) ? bus.avs_writedata[N-1:0] : '0;
      rises = m_stable & ~m_stable_d;
      pop   = 0;
      for (int i = 0; i < N; i++) pop += int'(rises[i]);
      sum = {1'b0, m_evcnt} + 33'(pop);
      if (bus.avs_write && bus.avs_address == 2'd3) m_evcnt = '0;
      else if (sum > 33'h0_FFFF_FFFF)               m_evcnt = 32'hFFFF_FFFF;
      else                                          m_evcnt = sum[31:0];
      m_edge = (m_edge & ~clr) | (m_stable ^ m_stable_d);
      if (bus.avs_write && bus.avs_address == 2'd2) m_mask = bus.avs_writedata[N-1:0];
      // window: samples seen by the debounce stage over the last D edges
      nxt_stable = m_stable;
      for (int i = 0; i < N; i++) begin
         flip = 1'b1;
         for (int k = 1; k <= D; k++) if (m_q[k][i] == m_stable[i]) flip = 1'b0;
         if (flip) nxt_stable[i] = ~m_stable[i];
      end
      m_stable_d = m_stable;
      m_stable   = nxt_stable;
      m_q.push_front(sw_in);
      void'(m_q.pop_back());
   endtask

   // one clock: model at the rising edge, DUT sampled at the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("rdata", bus.avs_readdata, m_rd);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      cycle();
      bus.avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      cycle();
      bus.avs_read    = 1'b0;
      d = bus.avs_readdata;
   endtask

   initial begin
      logic [31:0] d;
      int          first;
      int          seg;

      reset_n           = 1'b0;
      sw_in             = 4'hF;
      bus.avs_address   = '0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      model_reset();

      // ---------------- reset ----------------
      repeat (3) cycle();
      bus_read(2'd0, d);
      check("rst_data", d, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;
      repeat (12) cycle();
      bus_read(2'd0, d);
      check("rst_release_data", d, 32'hF);
      bus_read(2'd1, d);
      check("rst_release_edge", d, 32'hF);

      // bring all switches low and clear edges
      bus_write(2'd1, 32'hF);
      sw_in = 4'h0;
      repeat (14) cycle();
      bus_write(2'd1, 32'hF);
      cycle();

      // ---------------- bounce ----------------
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) sw_in[0] = ~sw_in[0];
         cycle();
      end
      sw_in[0] = 1'b1;
      // stable rises on edge 10 after the transition, so a read issued on
      // edge 11 is the first to return it
      first = 0;
      bus.avs_address = 2'd0;
      bus.avs_read    = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         cycle();
         if (first == 0 && bus.avs_readdata[0]) first = n;
      end
      bus.avs_read = 1'b0;
      check("bounce_latency", 32'(first), 32'd11);
      bus_read(2'd1, d);
      check("bounce_edge", d, 32'h1);
      bus_write(2'd1, 32'h1);
      repeat (15) cycle();
      bus_read(2'd1, d);
      check("bounce_edge_once", d, 32'h0);

      // ---------------- irq ----------------
      bus_write(2'd2, 32'h2);
      sw_in[1] = 1'b1;
      first = 0;
      for (int n = 1; n <= 30; n++) begin
         cycle();
         if (first == 0 && irq) first = n;
      end
      check("irq_latency", 32'(first), 32'd12);
      bus_write(2'd1, 32'h2);
      check("irq_hold_one", {31'd0, irq}, 32'h1);
      cycle();
      check("irq_cleared", {31'd0, irq}, 32'h0);
      sw_in[0] = 1'b0;
      for (int n = 0; n < 15; n++) begin
         cycle();
         check("irq_masked", {31'd0, irq}, 32'h0);
      end
      bus_read(2'd1, d);
      check("masked_edge_set", d, 32'h1);
      bus_write(2'd1, 32'hF);

      // ---------------- W1C race ----------------
      sw_in[0] = 1'b1;
      repeat (10) cycle();
      bus.avs_address   = 2'd1;
      bus.avs_writedata = 32'h1;
      bus.avs_write     = 1'b1;
      cycle();
      bus.avs_write     = 1'b0;
      bus_read(2'd1, d);
      check("w1c_race", d, 32'h1);

      // ---------------- read timing / read+write ----------------
      bus_write(2'd2, 32'hA);
      bus_read(2'd2, d);
      check("rd_mask", d, 32'h0000_000A);
      cycle();
      check("rd_idle_zero", bus.avs_readdata, 32'h0);
      bus.avs_address   = 2'd2;
      bus.avs_writedata = 32'h5;
      bus.avs_read      = 1'b1;
      bus.avs_write     = 1'b1;
      cycle();
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      check("rw_pre_value", bus.avs_readdata, 32'hA);
      bus_read(2'd2, d);
      check("rw_post_value", d, 32'h5);

      // ---------------- event counter ----------------
      sw_in = 4'h0;
      repeat (14) cycle();
      bus_write(2'd3, 32'h0);
      sw_in[0] = 1'b1;
      repeat (5) cycle();
      sw_in[2:1] = 2'b11;
      repeat (16) cycle();
      bus_read(2'd3, d);
`ifdef SW_DEBOUNCE_CORE_EVCNT_EN
      check("evcnt_three", d, 32'd3);
`else
      check("evcnt_absent", d, 32'd0);
`endif
      bus_write(2'd3, 32'h0);
      bus_read(2'd3, d);
      check("evcnt_cleared", d, 32'd0);
`ifdef SW_DEBOUNCE_CORE_EVCNT_EN
      force dut.evcnt = 32'hFFFF_FFFF;
      m_evcnt = 32'hFFFF_FFFF;
      cycle();
      release dut.evcnt;
      cycle();
      sw_in[3] = 1'b1;
      repeat (14) cycle();
      bus_read(2'd3, d);
      check("evcnt_saturated", d, 32'hFFFF_FFFF);
`endif

      // ---------------- randomized traffic ----------------
      seg = 0;
      for (int n = 0; n < 800; n++) begin
         if (seg == 0) begin
            sw_in = 4'($urandom);
            seg   = $urandom_range(1, 14);
         end
         seg--;
         bus.avs_address   = 2'($urandom);
         bus.avs_writedata = $urandom;
         bus.avs_read      = ($urandom_range(0, 3) == 0);
         bus.avs_write     = ($urandom_range(0, 7) == 0);
         cycle();
      end
      bus.avs_read  = 1'b0;
      bus.avs_write = 1'b0;
      cycle();

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
